vc_sram_reader: RTL and testbench
=================================

VC_SRAM_READER -- requirements
Module: vc_sram_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 12, SHALL set the word width of memory read data and output data.
REQ-002 Parameter NUM_WORDS, default 16, SHALL set the memory depth.
REQ-003 Parameter ADDR_WIDTH, default $clog2(NUM_WORDS), SHALL be derived and SHALL NOT be set manually.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_val  input  1  burst command valid.
REQ-007 cmd_rdy  output  1  burst command accepted when cmd_val && cmd_rdy.
REQ-008 cmd_addr  input  ADDR_WIDTH  burst start address.
REQ-009 cmd_len  input  ADDR_WIDTH+1  word count, 0..NUM_WORDS.
REQ-010 rdaddress  output  ADDR_WIDTH  read address to the 1R1W memory.
REQ-011 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after the matching rdaddress.
REQ-012 out_val / out_rdy  output / input  1 / 1  output stream handshake.
REQ-013 out_data  output  DATA_WIDTH  output word.
REQ-014 out_last  output  1  high with the final word of a burst.
REQ-015 busy  output  1  high from command accept until the final word is dequeued.

Function
REQ-016 FSM states SHALL be IDLE, READ and DRAIN; cmd_rdy SHALL equal (state == IDLE).
REQ-017 On accept with cmd_len > 0: IDLE->READ, with the address register loaded from cmd_addr and the remaining count loaded from cmd_len.
REQ-018 On accept with cmd_len == 0: remain in IDLE, produce no output, keep busy low.
REQ-019 In READ, a read SHALL issue in a cycle only if remaining > 0 and (buffer_count + inflight - deq) < 2, where deq = out_val && out_rdy.
REQ-020 rdaddress SHALL be driven combinationally from the address register while in READ; its value in other states is don't-care and SHALL NOT count as a read.
REQ-021 On each issued read: address += 1 modulo NUM_WORDS (wraps NUM_WORDS-1 -> 0) and remaining -= 1.
REQ-022 mem_rdata SHALL be written into the 2-entry output buffer on the cycle after the read was issued; the output buffer SHALL never overflow.
REQ-023 Latency: accept in cycle C, first rdaddress in C+1, first out_val in C+3.
REQ-024 Throughput SHALL be 1 word/cycle while out_rdy is held high.
REQ-025 READ->DRAIN when the last read issues; DRAIN->IDLE when the final word is dequeued, so a new command can be accepted on the following cycle.
REQ-026 out_last SHALL be high exactly with the cmd_len-th word.
REQ-027 out_data SHALL be held stable while out_val && !out_rdy.
REQ-028 cmd_val SHALL be ignored outside IDLE.

Reset
REQ-029 While reset is high: state = IDLE; cmd_rdy = 1; out_val = 0; out_last = 0; busy = 0; rdaddress = 0; out_data = 0; buffer empty; inflight = 0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; read data returning in the cycle after reset SHALL be discarded.

Configuration
REQ-031 With VC_SRAM_READER_STALL_CNT_EN defined, the block SHALL add output port stall_cnt (16 bits), which counts cycles with out_val && !out_rdy, saturates at 0xFFFF, clears on command accept, and resets to 0.
REQ-032 Without VC_SRAM_READER_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-033 Package vc_sram_pkg SHALL hold the FSM state enum typedef and the output-buffer depth constant (2).
REQ-034 The output buffer SHALL be the sub-module vc_sram_reader_buf: a 2-entry FIFO with enq/deq and a count output.

Verification
REQ-035 Memory preloaded with mem[i] = i+0x100; cmd addr=3, len=4, out_rdy held high -> out_data 0x103..0x106 on consecutive cycles starting at C+3; out_last only on 0x106.
REQ-036 Wrap: addr=14, len=4, NUM_WORDS=16 -> rdaddress sequence 14, 15, 0, 1.
REQ-037 Backpressure: len=8 with out_rdy toggling 1,0,0,1 -> all 8 words delivered in order, none dropped or duplicated, out_data stable during stalls, buffer never exceeds 2 entries.
REQ-038 len=0 -> no out_val, busy stays 0, cmd_rdy stays 1.
REQ-039 Reset pulsed during the 3rd word of a len=6 burst -> out_val = 0 the next cycle; a new burst addr=0, len=2 then delivers exactly 0x100 and 0x101.
REQ-040 With VC_SRAM_READER_STALL_CNT_EN defined: 5 stall cycles during a burst -> stall_cnt = 5; stall_cnt reads 0 after the next command is accepted.

Source files
------------

// File: rtl/vc_sram_pkg.sv
// vc_sram_pkg: shared types and constants for the SRAM burst reader.
//   state_e    - reader FSM states (IDLE, READ, DRAIN)
//   BUF_DEPTH  - output buffer depth; the read-issue throttle assumes 2
//   BUF_CNT_W  - width of the buffer occupancy count
//   STALL_CNT_W - width of the optional stall counter
package vc_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned BUF_DEPTH   = 2;
  localparam int unsigned BUF_CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/vc_sram_reader_buf.sv
// vc_sram_reader_buf: small FIFO holding words returned by the memory until
// the output stream accepts them.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset (pointers and count only)
//   enq_i      - write enq_data_i this cycle
//   enq_data_i - word to store
//   deq_i      - drop the head entry this cycle
//   deq_data_o - current head entry (meaningful while count_o != 0)
//   count_o    - number of valid entries
// The caller guarantees no enqueue while full and no dequeue while empty.
module vc_sram_reader_buf
  import vc_sram_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_i,
  input  logic [WIDTH-1:0]     enq_data_i,
  input  logic                 deq_i,
  output logic [WIDTH-1:0]     deq_data_o,
  output logic [BUF_CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [BUF_CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + BUF_CNT_W'(enq_i) - BUF_CNT_W'(deq_i);
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

  assign deq_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/vc_sram_reader.sv
// vc_sram_reader: reads a burst of consecutive words (wrapping at NUM_WORDS)
// from a 1R1W memory with one-cycle read latency and streams them out
// through a valid/ready interface.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   cmd_val/cmd_rdy       - burst command handshake (ready only in IDLE)
//   cmd_addr, cmd_len     - start address and word count (0..NUM_WORDS)
//   rdaddress             - memory read address (valid only while reading)
//   mem_rdata             - memory data, one cycle after rdaddress
//   out_val/out_rdy       - output stream handshake
//   out_data, out_last    - output word and end-of-burst marker
//   busy                  - burst in progress
//   stall_cnt             - (only with VC_SRAM_READER_STALL_CNT_EN) count of
//                           cycles with out_val && !out_rdy, saturating,
//                           cleared on command accept
module vc_sram_reader
  import vc_sram_pkg::*;
#(
  parameter  int DATA_WIDTH = 12,
  parameter  int NUM_WORDS  = 16,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_val,
  output logic                  cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
`ifdef VC_SRAM_READER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remain_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  accept;
  logic                  deq;
  logic                  issue;
  logic                  last_rd;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [BUF_CNT_W-1:0]  buf_cnt;
  logic [BUF_CNT_W:0]    occ_after;
  logic [DATA_WIDTH:0]   head;

  assign accept = cmd_val && (state_q == ST_IDLE);
  assign deq    = out_val && out_rdy;

  // Occupancy the buffer will have once this cycle's returning read lands
  // and this cycle's dequeue leaves; a new read only fits if that is below
  // the depth.
  assign occ_after = {1'b0, buf_cnt}
                   + {{BUF_CNT_W{1'b0}}, inflight_q}
                   - {{BUF_CNT_W{1'b0}}, deq};

  assign issue   = (state_q == ST_READ) && (remain_q != '0)
                && (occ_after < (BUF_CNT_W + 1)'(BUF_DEPTH));
  assign last_rd = issue && (remain_q == (ADDR_WIDTH + 1)'(1));

  assign addr_d = (addr_q == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0
                                                         : addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= last_rd;
      unique case (state_q)
        ST_IDLE: begin
          if (accept && (cmd_len != '0)) begin
            state_q  <= ST_READ;
            addr_q   <= cmd_addr;
            remain_q <= cmd_len;
          end
        end
        ST_READ: begin
          if (issue) begin
            addr_q   <= addr_d;
            remain_q <= remain_q - (ADDR_WIDTH + 1)'(1);
            if (last_rd) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (deq && out_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The end-of-burst flag travels with its word through the buffer.
  vc_sram_reader_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .enq_i      (inflight_q),
    .enq_data_i ({inflight_last_q, mem_rdata}),
    .deq_i      (deq),
    .deq_data_o (head),
    .count_o    (buf_cnt)
  );

  assign cmd_rdy   = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rdaddress = (state_q == ST_READ) ? addr_q : '0;
  assign out_val   = (buf_cnt != '0);
  // Zeroed when empty so unreset buffer storage never leaks onto the port.
  assign out_data  = out_val ? head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_val && head[DATA_WIDTH];

`ifdef VC_SRAM_READER_STALL_CNT_EN
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + STALL_CNT_W'(1);
  endfunction

  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if (out_val && !out_rdy) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vc_sram_reader.sv
// tb_vc_sram_reader: directed bench for vc_sram_reader with a behavioural
// one-cycle-latency memory and an in-order scoreboard of expected words.
// Define VC_SRAM_READER_STALL_CNT_EN to also exercise the stall counter.
module tb_vc_sram_reader;

  localparam int DW = 12;
  localparam int NW = 16;
  localparam int AW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_val;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] mem_rdata;
  logic          out_val;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef VC_SRAM_READER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  logic [DW-1:0] mem [NW];
  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            npop    = 0;
  logic          stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;

  vc_sram_reader #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_val  (cmd_val),
    .cmd_rdy  (cmd_rdy),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .rdaddress(rdaddress),
    .mem_rdata(mem_rdata),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
`ifdef VC_SRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[rdaddress];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks that
  // a stalled word stays put until accepted.
  always @(negedge clk) begin
    if (!reset && stall_pend) begin
      chk("stall_val_hold", 32'(out_val), 32'd1);
      chk("stall_data_hold", 32'(out_data), 32'(stall_data));
    end
    stall_pend = !reset && out_val && !out_rdy;
    stall_data = out_data;
    if (!reset && out_val && out_rdy) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
      npop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accept edge, i.e. early in cycle C+1.
  task automatic issue_cmd(input logic [AW-1:0] a, input logic [AW:0] l);
    exp_t e;
    logic [AW-1:0] idx;
    tick();
    chk("cmd_rdy_pre", 32'(cmd_rdy), 32'd1);
    cmd_val  = 1'b1;
    cmd_addr = a;
    cmd_len  = l;
    tick();
    cmd_val = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      idx    = a + AW'(i);
      e.d    = mem[idx];
      e.last = (i == int'(l) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(k < maxc), 32'd1);
  endtask

  initial begin
    int wrap_exp [4];
    int p0;
    logic [3:0] pat;
    for (int i = 0; i < NW; i++) mem[i] = DW'(i + 'h100);
    wrap_exp = '{14, 15, 0, 1};
    pat      = 4'b1001;
    reset    = 1'b1;
    cmd_val  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    out_rdy  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdaddress", 32'(rdaddress), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    tick();
    reset = 1'b0;

    // Basic burst: addr 3, len 4, latency and consecutive delivery
    p0 = npop;
    issue_cmd(4'd3, 5'd4);
    @(negedge clk);
    chk("c1_rdaddress", 32'(rdaddress), 32'd3);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_cmd_rdy", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    chk("c2_out_val", 32'(out_val), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_val", 32'(out_val), 32'd1);
      chk("burst_data", 32'(out_data), 32'('h103 + i));
      chk("burst_last", 32'(out_last), 32'(i == 3));
    end
    wait_idle("burst_timeout", 50);
    chk("burst_count", 32'(npop - p0), 32'd4);

    // Address wrap: 14,15,0,1
    issue_cmd(4'd14, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_rdaddress", 32'(rdaddress), 32'(wrap_exp[i]));
    end
    wait_idle("wrap_timeout", 50);

    // Backpressure: len 8 with out_rdy 1,0,0,1
    p0 = npop;
    issue_cmd(4'd5, 5'd8);
    for (int k = 0; k < 200 && (busy || sb.size() != 0); k++) begin
      out_rdy = pat[k % 4];
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_count", 32'(npop - p0), 32'd8);

    // Zero-length command
    p0 = npop;
    issue_cmd(4'd7, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_out_val", 32'(out_val), 32'd0);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_cmd_rdy", 32'(cmd_rdy), 32'd1);
    end
    chk("len0_count", 32'(npop - p0), 32'd0);

    // Reset during the 3rd word of a len-6 burst
    issue_cmd(4'd0, 5'd6);
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_word3", 32'(out_data), 32'h102);
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("postrst_out_val", 32'(out_val), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("postrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    chk("postrst_out_val2", 32'(out_val), 32'd0);
    p0 = npop;
    issue_cmd(4'd0, 5'd2);
    wait_idle("postrst_timeout", 50);
    chk("postrst_count", 32'(npop - p0), 32'd2);

`ifdef VC_SRAM_READER_STALL_CNT_EN
    // Five stall cycles, then clear on next accept
    begin
      int k;
      out_rdy = 1'b0;
      issue_cmd(4'd2, 5'd4);
      k = 0;
      while (!out_val && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("stall_wait", 32'(k < 20), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      out_rdy = 1'b1;
      wait_idle("stall_timeout", 50);
      chk("stall_cnt5", 32'(stall_cnt), 32'd5);
      issue_cmd(4'd0, 5'd0);
      @(negedge clk);
      chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
    end
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
